// File: rtl/idex_stage_if.sv
// Purpose: bundles the ID-stage inputs and ID/EX outputs of idex_stage.
// Latency: none, this is wiring only.
// Backpressure: Stall/PCWrite/IFIDWrite carry hold requests back to IF and ID.
//
// Port summary (slave = the pipeline register, master = whoever drives ID):
//   Freeze, Flush                 global hold and branch squash
//   IFIDRs/IFIDRt/IDRd/IDUsesRt   register specifiers of the instruction in ID
//   IDReadData1/2, IDImm          decode operands
//   IDWB, IDM, IDEX_in            control bundles from the decoder
//   MEMWB_RW/MEMWBRd/MEMWBData    write-back port used by the decode bypass
//   IDEX*                         registered outputs feeding EX and forwarding
//   Stall, PCWrite, IFIDWrite     combinational hazard controls
//   StallCount                    saturating bubble counter
interface idex_stage_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              Freeze;
  logic              Flush;
  logic [4:0]        IFIDRs;
  logic [4:0]        IFIDRt;
  logic [4:0]        IDRd;
  logic              IDUsesRt;
  logic [DATA_W-1:0] IDReadData1;
  logic [DATA_W-1:0] IDReadData2;
  logic [DATA_W-1:0] IDImm;
  logic [1:0]        IDWB;
  logic [1:0]        IDM;
  logic [3:0]        IDEX_in;
  logic [1:0]        MEMWB_RW;
  logic [4:0]        MEMWBRd;
  logic [DATA_W-1:0] MEMWBData;

  logic [4:0]        IDEXRs;
  logic [4:0]        IDEXRt;
  logic [4:0]        IDEXRd;
  logic [DATA_W-1:0] IDEXReadData1;
  logic [DATA_W-1:0] IDEXReadData2;
  logic [DATA_W-1:0] IDEXImm;
  logic [1:0]        IDEX_WB;
  logic [1:0]        IDEX_M;
  logic [3:0]        IDEX_EX;
  logic              IDEXValid;
  logic              Stall;
  logic              PCWrite;
  logic              IFIDWrite;
  logic [CNT_W-1:0]  StallCount;

  modport master (
    output Freeze, Flush, IFIDRs, IFIDRt, IDRd, IDUsesRt,
           IDReadData1, IDReadData2, IDImm, IDWB, IDM, IDEX_in,
           MEMWB_RW, MEMWBRd, MEMWBData,
    input  IDEXRs, IDEXRt, IDEXRd, IDEXReadData1, IDEXReadData2, IDEXImm,
           IDEX_WB, IDEX_M, IDEX_EX, IDEXValid, Stall, PCWrite, IFIDWrite,
           StallCount
  );

  modport slave (
    input  Freeze, Flush, IFIDRs, IFIDRt, IDRd, IDUsesRt,
           IDReadData1, IDReadData2, IDImm, IDWB, IDM, IDEX_in,
           MEMWB_RW, MEMWBRd, MEMWBData,
    output IDEXRs, IDEXRt, IDEXRd, IDEXReadData1, IDEXReadData2, IDEXImm,
           IDEX_WB, IDEX_M, IDEX_EX, IDEXValid, Stall, PCWrite, IFIDWrite,
           StallCount
  );
endinterface

// File: rtl/idex_stage.sv
// Purpose: ID/EX pipeline register with load-use hazard detection and WB->ID bypass.
// Latency: 1 cycle ID to EX; Stall/PCWrite/IFIDWrite are combinational.
// Backpressure: load-use inserts one bubble and holds PC/IF-ID; Freeze holds everything.
//
// Ports:
//   clk    clock, all state updates on posedge
//   reset  asynchronous active-low reset, clears every register
//   bus    idex_stage_if.slave, decode inputs in, ID/EX state and hazard controls out
module idex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic         clk,
  input  logic         reset,
  idex_stage_if.slave  bus
);

  logic [4:0]        rs_q,   rs_d;
  logic [4:0]        rt_q,   rt_d;
  logic [4:0]        rd_q,   rd_d;
  logic [DATA_W-1:0] op1_q,  op1_d;
  logic [DATA_W-1:0] op2_q,  op2_d;
  logic [DATA_W-1:0] imm_q,  imm_d;
  logic [1:0]        wb_q,   wb_d;
  logic [1:0]        m_q,    m_d;
  logic [3:0]        ex_q,   ex_d;
  logic              vld_q,  vld_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;

  logic              hazard;
  logic              stall;
  logic              byp_rs;
  logic              byp_rt;
  logic [DATA_W-1:0] op1_in;
  logic [DATA_W-1:0] op2_in;
  logic              unused_memwb_memtoreg;

  // Only RegWrite of the MEM/WB bundle matters for the bypass.
  assign unused_memwb_memtoreg = bus.MEMWB_RW[1];

  // Load-use: a valid load in ID/EX whose destination (Rt) is a source of ID.
  // Rt only counts as a source when the decoder says so (R-type, branches, stores).
  always_comb begin
    hazard = 1'b0;
    if (vld_q && m_q[1] && (rt_q != 5'd0)) begin
      hazard = (rt_q == bus.IFIDRs) ||
               ((rt_q == bus.IFIDRt) && bus.IDUsesRt);
    end
  end

  // A flushed instruction is squashed anyway, so no bubble is needed for it.
  assign stall         = hazard && !bus.Flush;
  assign bus.Stall     = stall;
  assign bus.PCWrite   = !bus.Freeze && !stall;
  assign bus.IFIDWrite = !bus.Freeze && !stall;

  // Register-file write happening this cycle is not yet visible on the read
  // ports, so take it straight from MEM/WB. r0 is hard-wired and never bypassed.
  assign byp_rs = bus.MEMWB_RW[0] && (bus.MEMWBRd != 5'd0) && (bus.MEMWBRd == bus.IFIDRs);
  assign byp_rt = bus.MEMWB_RW[0] && (bus.MEMWBRd != 5'd0) && (bus.MEMWBRd == bus.IFIDRt);
  assign op1_in = byp_rs ? bus.MEMWBData : bus.IDReadData1;
  assign op2_in = byp_rt ? bus.MEMWBData : bus.IDReadData2;

  // Next state. Priority: Freeze > Flush > Stall > normal load.
  always_comb begin
    rs_d  = rs_q;
    rt_d  = rt_q;
    rd_d  = rd_q;
    op1_d = op1_q;
    op2_d = op2_q;
    imm_d = imm_q;
    wb_d  = wb_q;
    m_d   = m_q;
    ex_d  = ex_q;
    vld_d = vld_q;
    cnt_d = cnt_q;
    if (!bus.Freeze) begin
      // Data and specifiers always follow ID; only control decides validity.
      rs_d  = bus.IFIDRs;
      rt_d  = bus.IFIDRt;
      rd_d  = bus.IDRd;
      op1_d = op1_in;
      op2_d = op2_in;
      imm_d = bus.IDImm;
      if (bus.Flush) begin
        wb_d  = 2'b00;
        m_d   = 2'b00;
        ex_d  = 4'b0000;
        vld_d = 1'b0;
      end else if (stall) begin
        // Bubble: zeroed controls keep RegWrite/MemRead/MemWrite low downstream.
        wb_d  = 2'b00;
        m_d   = 2'b00;
        ex_d  = 4'b0000;
        vld_d = 1'b0;
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end else begin
        wb_d  = bus.IDWB;
        m_d   = bus.IDM;
        ex_d  = bus.IDEX_in;
        vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs_q  <= 5'd0;
      rt_q  <= 5'd0;
      rd_q  <= 5'd0;
      op1_q <= '0;
      op2_q <= '0;
      imm_q <= '0;
      wb_q  <= 2'b00;
      m_q   <= 2'b00;
      ex_q  <= 4'b0000;
      vld_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      rs_q  <= rs_d;
      rt_q  <= rt_d;
      rd_q  <= rd_d;
      op1_q <= op1_d;
      op2_q <= op2_d;
      imm_q <= imm_d;
      wb_q  <= wb_d;
      m_q   <= m_d;
      ex_q  <= ex_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.IDEXRs        = rs_q;
  assign bus.IDEXRt        = rt_q;
  assign bus.IDEXRd        = rd_q;
  assign bus.IDEXReadData1 = op1_q;
  assign bus.IDEXReadData2 = op2_q;
  assign bus.IDEXImm       = imm_q;
  assign bus.IDEX_WB       = wb_q;
  assign bus.IDEX_M        = m_q;
  assign bus.IDEX_EX       = ex_q;
  assign bus.IDEXValid     = vld_q;
  assign bus.StallCount    = cnt_q;

endmodule

// File: tb/tb_idex_stage.sv
// Purpose: directed table-driven bench for idex_stage plus saturation and async-reset sequences.
// Latency: each table row is one clock; combinational outputs checked before the edge.
// Backpressure: Freeze/Flush/Stall interactions are covered by dedicated rows.
module tb_idex_stage;
  localparam int DW = 32;
  localparam int CW = 8;
  localparam int NV = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  idex_stage_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  idex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        frz;
    logic        fl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        use_rt;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [1:0]  wb;
    logic [1:0]  m;
    logic [3:0]  ex;
    logic [1:0]  mrw;
    logic [4:0]  mrd;
    logic [31:0] mdat;
    logic        e_stall;
    logic        e_pcw;
    logic [4:0]  e_rs;
    logic [4:0]  e_rt;
    logic [4:0]  e_rd;
    logic [31:0] e_d1;
    logic [31:0] e_d2;
    logic [31:0] e_imm;
    logic [1:0]  e_wb;
    logic [1:0]  e_m;
    logic [3:0]  e_ex;
    logic        e_val;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vecs [NV];
  int   n_chk = 0;
  int   n_err = 0;
  int   step  = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", nm, step, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.Freeze      = v.frz;
    bus.Flush       = v.fl;
    bus.IFIDRs      = v.rs;
    bus.IFIDRt      = v.rt;
    bus.IDRd        = v.rd;
    bus.IDUsesRt    = v.use_rt;
    bus.IDReadData1 = v.d1;
    bus.IDReadData2 = v.d2;
    bus.IDImm       = v.imm;
    bus.IDWB        = v.wb;
    bus.IDM         = v.m;
    bus.IDEX_in     = v.ex;
    bus.MEMWB_RW    = v.mrw;
    bus.MEMWBRd     = v.mrd;
    bus.MEMWBData   = v.mdat;
  endtask

  task automatic check_comb(input vec_t v);
    chk("Stall",     32'(bus.Stall),     32'(v.e_stall));
    chk("PCWrite",   32'(bus.PCWrite),   32'(v.e_pcw));
    chk("IFIDWrite", 32'(bus.IFIDWrite), 32'(v.e_pcw));
  endtask

  task automatic check_regs(input vec_t v);
    chk("IDEXRs",        32'(bus.IDEXRs),     32'(v.e_rs));
    chk("IDEXRt",        32'(bus.IDEXRt),     32'(v.e_rt));
    chk("IDEXRd",        32'(bus.IDEXRd),     32'(v.e_rd));
    chk("IDEXReadData1", bus.IDEXReadData1,   v.e_d1);
    chk("IDEXReadData2", bus.IDEXReadData2,   v.e_d2);
    chk("IDEXImm",       bus.IDEXImm,         v.e_imm);
    chk("IDEX_WB",       32'(bus.IDEX_WB),    32'(v.e_wb));
    chk("IDEX_M",        32'(bus.IDEX_M),     32'(v.e_m));
    chk("IDEX_EX",       32'(bus.IDEX_EX),    32'(v.e_ex));
    chk("IDEXValid",     32'(bus.IDEXValid),  32'(v.e_val));
    chk("StallCount",    32'(bus.StallCount), 32'(v.e_cnt));
  endtask

  task automatic check_all_zero();
    chk("rst_IDEXRs",     32'(bus.IDEXRs),     32'h0);
    chk("rst_IDEXRt",     32'(bus.IDEXRt),     32'h0);
    chk("rst_IDEXRd",     32'(bus.IDEXRd),     32'h0);
    chk("rst_ReadData1",  bus.IDEXReadData1,   32'h0);
    chk("rst_ReadData2",  bus.IDEXReadData2,   32'h0);
    chk("rst_Imm",        bus.IDEXImm,         32'h0);
    chk("rst_IDEX_WB",    32'(bus.IDEX_WB),    32'h0);
    chk("rst_IDEX_M",     32'(bus.IDEX_M),     32'h0);
    chk("rst_IDEX_EX",    32'(bus.IDEX_EX),    32'h0);
    chk("rst_IDEXValid",  32'(bus.IDEXValid),  32'h0);
    chk("rst_StallCount", 32'(bus.StallCount), 32'h0);
    chk("rst_Stall",      32'(bus.Stall),      32'h0);
    chk("rst_PCWrite",    32'(bus.PCWrite),    32'h1);
    chk("rst_IFIDWrite",  32'(bus.IFIDWrite),  32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    //          frz   fl    rs    rt    rd    use   d1             d2             imm        wb     m      ex       mrw    mrd   mdat           | stall pcw  e_rs  e_rt  e_rd  e_d1           e_d2           e_imm      e_wb   e_m    e_ex     val   cnt
    // add r3,r1,r2
    vecs[0]  = '{1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 32'h11,        32'h22,        32'h0,     2'b01, 2'b00, 4'b0100, 2'b00, 5'd0, 32'h0,         1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 32'h11,        32'h22,        32'h0,     2'b01, 2'b00, 4'b0100, 1'b1, 8'd0};
    // lw r5,8(r1)
    vecs[1]  = '{1'b0, 1'b0, 5'd1, 5'd5, 5'd5, 1'b0, 32'h100,       32'h0,         32'h8,     2'b11, 2'b10, 4'b0001, 2'b00, 5'd0, 32'h0,         1'b0, 1'b1, 5'd1, 5'd5, 5'd5, 32'h100,       32'h0,         32'h8,     2'b11, 2'b10, 4'b0001, 1'b1, 8'd0};
    // add r6,r5,r7 -> load-use bubble
    vecs[2]  = '{1'b0, 1'b0, 5'd5, 5'd7, 5'd6, 1'b1, 32'h55,        32'h77,        32'h0,     2'b01, 2'b00, 4'b0100, 2'b00, 5'd0, 32'h0,         1'b1, 1'b0, 5'd5, 5'd7, 5'd6, 32'h55,        32'h77,        32'h0,     2'b00, 2'b00, 4'b0000, 1'b0, 8'd1};
    // same add re-presented by the held IF/ID -> enters normally
    vecs[3]  = '{1'b0, 1'b0, 5'd5, 5'd7, 5'd6, 1'b1, 32'h55,        32'h77,        32'h0,     2'b01, 2'b00, 4'b0100, 2'b00, 5'd0, 32'h0,         1'b0, 1'b1, 5'd5, 5'd7, 5'd6, 32'h55,        32'h77,        32'h0,     2'b01, 2'b00, 4'b0100, 1'b1, 8'd1};
    // lw r0,4(r2)
    vecs[4]  = '{1'b0, 1'b0, 5'd2, 5'd0, 5'd0, 1'b0, 32'h200,       32'h0,         32'h4,     2'b11, 2'b10, 4'b0001, 2'b00, 5'd0, 32'h0,         1'b0, 1'b1, 5'd2, 5'd0, 5'd0, 32'h200,       32'h0,         32'h4,     2'b11, 2'b10, 4'b0001, 1'b1, 8'd1};
    // add r8,r0,r0: r0 load never stalls
    vecs[5]  = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd8, 1'b1, 32'h0,         32'h0,         32'h0,     2'b01, 2'b00, 4'b0100, 2'b00, 5'd0, 32'h0,         1'b0, 1'b1, 5'd0, 5'd0, 5'd8, 32'h0,         32'h0,         32'h0,     2'b01, 2'b00, 4'b0100, 1'b1, 8'd1};
    // lw r5,12(r1)
    vecs[6]  = '{1'b0, 1'b0, 5'd1, 5'd5, 5'd5, 1'b0, 32'h100,       32'h0,         32'hC,     2'b11, 2'b10, 4'b0001, 2'b00, 5'd0, 32'h0,         1'b0, 1'b1, 5'd1, 5'd5, 5'd5, 32'h100,       32'h0,         32'hC,     2'b11, 2'b10, 4'b0001, 1'b1, 8'd1};
    // addi r5,r1,4: Rt matches but is not a source
    vecs[7]  = '{1'b0, 1'b0, 5'd1, 5'd5, 5'd5, 1'b0, 32'h100,       32'h0,         32'h4,     2'b01, 2'b00, 4'b0001, 2'b00, 5'd0, 32'h0,         1'b0, 1'b1, 5'd1, 5'd5, 5'd5, 32'h100,       32'h0,         32'h4,     2'b01, 2'b00, 4'b0001, 1'b1, 8'd1};
    // add r10,r4,r2 with MEM/WB writing r4=DEADBEEF -> Rs bypass
    vecs[8]  = '{1'b0, 1'b0, 5'd4, 5'd2, 5'd10,1'b1, 32'h0,         32'h22,        32'h0,     2'b01, 2'b00, 4'b0100, 2'b01, 5'd4, 32'hDEADBEEF,  1'b0, 1'b1, 5'd4, 5'd2, 5'd10,32'hDEADBEEF,  32'h22,        32'h0,     2'b01, 2'b00, 4'b0100, 1'b1, 8'd1};
    // MEM/WB writing r0 while Rs=0 -> no bypass
    vecs[9]  = '{1'b0, 1'b0, 5'd0, 5'd4, 5'd11,1'b1, 32'h0,         32'h44,        32'h0,     2'b01, 2'b00, 4'b0100, 2'b01, 5'd0, 32'hDEADBEEF,  1'b0, 1'b1, 5'd0, 5'd4, 5'd11,32'h0,         32'h44,        32'h0,     2'b01, 2'b00, 4'b0100, 1'b1, 8'd1};
    // Rt bypass
    vecs[10] = '{1'b0, 1'b0, 5'd3, 5'd4, 5'd12,1'b1, 32'h33,        32'h0,         32'h0,     2'b01, 2'b00, 4'b0100, 2'b01, 5'd4, 32'hCAFEF00D,  1'b0, 1'b1, 5'd3, 5'd4, 5'd12,32'h33,        32'hCAFEF00D,  32'h0,     2'b01, 2'b00, 4'b0100, 1'b1, 8'd1};
    // MEM/WB RegWrite low (only MemtoReg) -> no bypass
    vecs[11] = '{1'b0, 1'b0, 5'd3, 5'd4, 5'd12,1'b1, 32'h33,        32'h12,        32'h0,     2'b01, 2'b00, 4'b0100, 2'b10, 5'd4, 32'hCAFEF00D,  1'b0, 1'b1, 5'd3, 5'd4, 5'd12,32'h33,        32'h12,        32'h0,     2'b01, 2'b00, 4'b0100, 1'b1, 8'd1};
    // lw r7,0(r1)
    vecs[12] = '{1'b0, 1'b0, 5'd1, 5'd7, 5'd7, 1'b0, 32'h100,       32'h0,         32'h0,     2'b11, 2'b10, 4'b0001, 2'b00, 5'd0, 32'h0,         1'b0, 1'b1, 5'd1, 5'd7, 5'd7, 32'h100,       32'h0,         32'h0,     2'b11, 2'b10, 4'b0001, 1'b1, 8'd1};
    // Flush with hazard present: no stall, squashed, count unchanged
    vecs[13] = '{1'b0, 1'b1, 5'd7, 5'd1, 5'd9, 1'b1, 32'h70,        32'h11,        32'h0,     2'b01, 2'b00, 4'b0100, 2'b00, 5'd0, 32'h0,         1'b0, 1'b1, 5'd7, 5'd1, 5'd9, 32'h70,        32'h11,        32'h0,     2'b00, 2'b00, 4'b0000, 1'b0, 8'd1};
    // lw r7,16(r1)
    vecs[14] = '{1'b0, 1'b0, 5'd1, 5'd7, 5'd7, 1'b0, 32'h100,       32'h0,         32'h10,    2'b11, 2'b10, 4'b0001, 2'b00, 5'd0, 32'h0,         1'b0, 1'b1, 5'd1, 5'd7, 5'd7, 32'h100,       32'h0,         32'h10,    2'b11, 2'b10, 4'b0001, 1'b1, 8'd1};
    // Freeze with hazard: Stall reported, nothing changes
    vecs[15] = '{1'b1, 1'b0, 5'd7, 5'd1, 5'd9, 1'b1, 32'h70,        32'h11,        32'h0,     2'b01, 2'b00, 4'b0100, 2'b00, 5'd0, 32'h0,         1'b1, 1'b0, 5'd1, 5'd7, 5'd7, 32'h100,       32'h0,         32'h10,    2'b11, 2'b10, 4'b0001, 1'b1, 8'd1};
    // Freeze, unrelated inputs and an active bypass
    vecs[16] = '{1'b1, 1'b0, 5'd2, 5'd3, 5'd4, 1'b1, 32'h99,        32'h98,        32'h5,     2'b01, 2'b01, 4'b0100, 2'b01, 5'd2, 32'h12345678,  1'b0, 1'b0, 5'd1, 5'd7, 5'd7, 32'h100,       32'h0,         32'h10,    2'b11, 2'b10, 4'b0001, 1'b1, 8'd1};
    // Freeze, hazard via Rt
    vecs[17] = '{1'b1, 1'b0, 5'd3, 5'd7, 5'd9, 1'b1, 32'h31,        32'h32,        32'h6,     2'b01, 2'b00, 4'b0100, 2'b00, 5'd0, 32'h0,         1'b1, 1'b0, 5'd1, 5'd7, 5'd7, 32'h100,       32'h0,         32'h10,    2'b11, 2'b10, 4'b0001, 1'b1, 8'd1};
    // Freeze released: the hazard now produces a bubble
    vecs[18] = '{1'b0, 1'b0, 5'd7, 5'd1, 5'd9, 1'b1, 32'h70,        32'h11,        32'h0,     2'b01, 2'b00, 4'b0100, 2'b00, 5'd0, 32'h0,         1'b1, 1'b0, 5'd7, 5'd1, 5'd9, 32'h70,        32'h11,        32'h0,     2'b00, 2'b00, 4'b0000, 1'b0, 8'd2};
    // After the bubble, load value arrives via MEM/WB bypass on r7
    vecs[19] = '{1'b0, 1'b0, 5'd7, 5'd1, 5'd9, 1'b1, 32'h70,        32'h11,        32'h0,     2'b01, 2'b00, 4'b0100, 2'b01, 5'd7, 32'h77,        1'b0, 1'b1, 5'd7, 5'd1, 5'd9, 32'h77,        32'h11,        32'h0,     2'b01, 2'b00, 4'b0100, 1'b1, 8'd2};

    // Reset held low with random ID inputs
    reset           = 1'b0;
    bus.Freeze      = 1'b0;
    bus.Flush       = 1'($urandom);
    bus.IFIDRs      = 5'($urandom);
    bus.IFIDRt      = 5'($urandom);
    bus.IDRd        = 5'($urandom);
    bus.IDUsesRt    = 1'($urandom);
    bus.IDReadData1 = $urandom;
    bus.IDReadData2 = $urandom;
    bus.IDImm       = $urandom;
    bus.IDWB        = 2'($urandom);
    bus.IDM         = 2'($urandom);
    bus.IDEX_in     = 4'($urandom);
    bus.MEMWB_RW    = 2'($urandom);
    bus.MEMWBRd     = 5'($urandom);
    bus.MEMWBData   = $urandom;
    #3;
    check_all_zero();
    @(posedge clk);
    #1;
    check_all_zero();
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      step = i;
      drive(vecs[i]);
      #1;
      check_comb(vecs[i]);
      @(posedge clk);
      #1;
      check_regs(vecs[i]);
      @(negedge clk);
    end

    // Saturation: StallCount is 2 here; 253 more bubbles reach all-ones.
    step = 100;
    for (int k = 0; k < 253; k++) begin
      drive(vecs[14]);
      @(negedge clk);
      drive(vecs[18]);
      @(negedge clk);
    end
    chk("sat_reach", 32'(bus.StallCount), 32'hFF);
    step = 101;
    drive(vecs[14]);
    @(negedge clk);
    drive(vecs[18]);
    #1;
    chk("sat_stall", 32'(bus.Stall), 32'h1);
    @(negedge clk);
    chk("sat_hold", 32'(bus.StallCount), 32'hFF);
    chk("sat_bubble_valid", 32'(bus.IDEXValid), 32'h0);

    // Reset asserted mid-stall clears state before any clock edge.
    step = 102;
    drive(vecs[14]);
    @(negedge clk);
    drive(vecs[18]);
    #1;
    chk("pre_rst_stall", 32'(bus.Stall), 32'h1);
    chk("pre_rst_valid", 32'(bus.IDEXValid), 32'h1);
    #1;
    reset = 1'b0;
    #1;
    check_all_zero();
    @(negedge clk);
    step = 103;
    reset = 1'b1;
    drive(vecs[0]);
    @(posedge clk);
    #1;
    check_regs(vecs[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/idex_stage.md
# idex_stage

ID/EX pipeline register with integrated load-use hazard detection and write-back-to-decode bypass for the 5-stage MIPS pipeline. It captures decode-stage operands, register specifiers and control bundles on each clock, and feeds the EX stage and the forwarding unit: IDEXRs, IDEXRt, IDEXRd and the WB control bundle. It generates the stall controls for PC and IF/ID, inserts bubbles on load-use hazards, squashes on branch flush, and counts bubble cycles.

## Interface
- DATA_W, 32, operand/immediate width
- CNT_W, 16, stall counter width

- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-low; clears all state
- Freeze  in  1  global hold (memory stall); all state holds
- Flush  in  1  branch taken; squash the instruction entering ID/EX
- IFIDRs, IFIDRt  in  5  source specifiers of the instruction in ID
- IDRd  in  5  destination already selected by RegDst in ID
- IDUsesRt  in  1  instruction in ID reads Rt as a source
- IDReadData1, IDReadData2  in  DATA_W  register-file read data
- IDImm  in  DATA_W  sign-extended immediate
- IDWB  in  2  bit0 RegWrite, bit1 MemtoReg
- IDM  in  2  bit0 MemWrite, bit1 MemRead
- IDEX_in  in  4  bit0 ALUSrc, bits2:1 ALUOp, bit3 reserved
- MEMWB_RW  in  2  WB bundle of MEM/WB (bit0 RegWrite)
- MEMWBRd  in  5  MEM/WB destination
- MEMWBData  in  DATA_W  value being written back
- IDEXRs, IDEXRt, IDEXRd  out  5  registered specifiers
- IDEXReadData1, IDEXReadData2, IDEXImm  out  DATA_W  registered operands
- IDEX_WB, IDEX_M  out  2  registered control bundles
- IDEX_EX  out  4  registered EX control
- IDEXValid  out  1  ID/EX holds a real instruction
- Stall  out  1  load-use hazard detected (combinational)
- PCWrite, IFIDWrite  out  1  enables for PC and IF/ID
- StallCount  out  CNT_W  saturating count of inserted bubbles

## Operation
- Hazard condition H: IDEXValid and IDEX_M[1] and IDEXRt != 0 and (IDEXRt == IFIDRs, or IDEXRt == IFIDRt with IDUsesRt).
- Stall = H and not Flush.
- PCWrite = IFIDWrite = not Freeze and not Stall.
- WB bypass: if MEMWB_RW[0], MEMWBRd != 0 and MEMWBRd == IFIDRs, capture MEMWBData as IDEXReadData1 instead of IDReadData1. The same rule applies to IFIDRt / IDEXReadData2. Register 0 is never bypassed.
- Per-edge priority: reset > Freeze > Flush > Stall > normal load.
  - Freeze: every register, including StallCount, holds.
  - Flush: IDEX_WB, IDEX_M, IDEX_EX and IDEXValid load 0. Data and specifier fields load the ID values. StallCount is unchanged.
  - Stall (bubble): control bundles and IDEXValid load 0. Data and specifiers load the ID values. StallCount increments, saturating at all-ones.
  - Normal: all fields load the ID values (with bypass applied), and IDEXValid loads 1.
- Bubble and flush entries never assert RegWrite, MemRead or MemWrite downstream.

## Timing
- Reset: every registered output is 0, including StallCount and IDEXValid.
  - Stall is 0 during reset, so PCWrite = IFIDWrite = 1 when Freeze = 0.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge. Release is synchronous to the next posedge.
- ID-to-EX latency: 1 cycle.
- Stall, PCWrite and IFIDWrite are combinational from current ID/EX state and ID inputs, valid in the same cycle.
- Load-use: a load in ID/EX plus a dependent instruction in ID gives exactly one bubble.
  - The next cycle, IDEX_M[1] = 0 (bubble), so Stall deasserts.
  - The dependent instruction then enters ID/EX, and forwarding from MEM/WB resolves the operand.
- Flush and H in the same cycle: Flush wins, Stall = 0, no increment.
- Freeze and H in the same cycle: Stall = 1 is reported, but no state changes and there is no increment.
- Bypass and load-use on the same register: bypass applies to data captured on the normal-load cycle after the bubble.
- StallCount at all-ones holds and does not wrap.

## Test plan
- Reset low with random inputs → all outputs 0, PCWrite = IFIDWrite = 1. Release reset; an add r3,r1,r2 in ID → next edge IDEXRs = 1, IDEXRt = 2, IDEXRd = 3, IDEXValid = 1, IDEX_WB = 2'b01.
- lw r5 in ID/EX, then add r6,r5,r7 in ID → Stall = 1, PCWrite = 0. Next edge: IDEX_M = 0, IDEXValid = 0, StallCount = 1, Stall = 0. Following edge: the add is in ID/EX with IDEXRs = 5.
- lw r0 in ID/EX followed by a consumer of r0 → Stall = 0. lw r5 with a consumer using r5 only as Rt and IDUsesRt = 0 → Stall = 0.
- MEM/WB writing r4 = 0xDEADBEEF, IDReadData1 = 0x0, IFIDRs = 4 → IDEXReadData1 = 0xDEADBEEF after the edge. The same scenario with MEMWBRd = 0 → IDEXReadData1 = 0x0.
- Flush together with a load-use hazard → Stall = 0, IDEXValid = 0, control bundles 0, StallCount unchanged. Freeze for 3 cycles → all outputs constant.
- Force StallCount to 0xFFFF via repeated hazards, then one more hazard → StallCount stays 0xFFFF. Assert reset mid-stall → outputs 0 before the next edge.
